// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative multiply/divide unit with HI/LO registers
// One shift-add or restoring-subtract step per cycle; sign fix-up is applied in FIX.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, state_d;
  logic [2*WIDTH:0] acc;
  logic [WIDTH-1:0] opnd;
  logic [CW-1:0]    count;
  logic             is_div, sign_a, sign_b, b_zero;

  logic             accept, signed_op;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod, mul_res;
  logic [WIDTH-1:0] quo, rem, quo_fix, rem_fix;

  assign busy      = (state != IDLE);
  assign stall     = start & busy;
  assign accept    = start & (state == IDLE) & ~flush;
  assign signed_op = ~md_op[0];
  assign abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;

  // acc holds {partial/remainder (WIDTH+1 bits), multiplier/quotient (WIDTH bits)}
  assign mul_sum   = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd};

  assign prod    = acc[2*WIDTH-1:0];
  assign mul_res = (sign_a ^ sign_b) ? -prod : prod;
  assign quo     = acc[WIDTH-1:0];
  assign rem     = acc[2*WIDTH-1:WIDTH];
  // With a zero divisor the remainder ends as |a|, so the sign rule restores a.
  assign quo_fix = b_zero ? {WIDTH{1'b1}} : ((sign_a ^ sign_b) ? -quo : quo);
  assign rem_fix = sign_a ? -rem : rem;

  always_comb begin
    rd_data = '0;
    if (start && state == IDLE) begin
      if (md_op == 3'b100) rd_data = hi;
      else if (md_op == 3'b101) rd_data = lo;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept && !md_op[2]) state_d = RUN;
      RUN:     if (flush) state_d = IDLE;
               else if (count == CW'(WIDTH-1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      opnd   <= '0;
      count  <= '0;
      is_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: if (accept) begin
          if (md_op == 3'b110) hi <= a;
          else if (md_op == 3'b111) lo <= a;
          else if (!md_op[2]) begin
            is_div <= md_op[1];
            sign_a <= signed_op & a[WIDTH-1];
            sign_b <= signed_op & b[WIDTH-1];
            b_zero <= (b == '0);
            count  <= '0;
            if (md_op[1]) begin
              acc  <= {{(WIDTH+1){1'b0}}, abs_a};
              opnd <= abs_b;
            end else begin
              acc  <= {{(WIDTH+1){1'b0}}, abs_b};
              opnd <= abs_a;
            end
          end
        end
        RUN: if (!flush) begin
          count <= count + 1'b1;
          if (!is_div)
            acc <= {1'b0, mul_sum, acc[WIDTH-1:1]};
          else if (!div_diff[WIDTH])
            acc <= {div_diff, acc[WIDTH-2:0], 1'b1};
          else
            acc <= {div_shift, acc[WIDTH-2:0], 1'b0};
        end
        FIX: if (!flush) begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= mul_res[2*WIDTH-1:WIDTH];
            lo <= mul_res[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
  localparam int W = 32;
  localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                         OP_DIVU = 3'b011, OP_MFHI = 3'b100, OP_MFLO = 3'b101,
                         OP_MTHI = 3'b110, OP_MTLO = 3'b111;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [2:0]   md_op;
  logic [W-1:0] a, b;
  logic         busy, stall;
  logic [W-1:0] rd_data, hi, lo;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .md_op(md_op), .a(a), .b(b),
    .flush(flush), .busy(busy), .stall(stall), .rd_data(rd_data), .hi(hi), .lo(lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    start = 1'b1; md_op = op; a = av; b = bv;
    tick();
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo);
    int n;
    n = 0;
    issue(op, av, bv);
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk($sformatf("%s busy_cycles", tag), 64'(n), 64'd33);
    chk($sformatf("%s hi", tag), {32'h0, hi}, {32'h0, exp_hi});
    chk($sformatf("%s lo", tag), {32'h0, lo}, {32'h0, exp_lo});
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; flush = 1'b0; md_op = 3'b000; a = '0; b = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset stall", 64'(stall), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);

    run_op("multu_max_x2", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("mult_m3_x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult_m5_xm6", OP_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0, 32'h0000_001E);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu_7_0", OP_DIVU, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF);
    run_op("div_m7_0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // MFLO arrives in the second busy cycle of a DIVU and must wait out the rest
    issue(OP_DIVU, 32'd100, 32'd7);
    tick();
    start = 1'b1; md_op = OP_MFLO;
    #1;
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk("mflo stall_cycles", 64'(n), 64'd32);
    chk("mflo rd_data", 64'(rd_data), 64'd14);
    chk("divu_100_7 hi", 64'(hi), 64'd2);
    chk("mflo busy", 64'(busy), 64'd0);
    tick();
    start = 1'b0;

    start = 1'b1; md_op = OP_MTHI; a = 32'h1234_5678;
    #1;
    chk("mthi stall", 64'(stall), 64'd0);
    tick();
    md_op = OP_MFHI;
    #1;
    chk("mthi busy", 64'(busy), 64'd0);
    chk("mfhi rd_data", 64'(rd_data), 64'h1234_5678);
    tick();
    start = 1'b0;
    chk("mfhi busy", 64'(busy), 64'd0);

    // flush in cycle 10 of a MULT leaves HI/LO untouched
    issue(OP_MULT, 32'd3, 32'd4);
    for (int i = 0; i < 9; i++) tick();
    chk("pre_flush busy", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush busy", 64'(busy), 64'd0);
    chk("flush hi", 64'(hi), 64'h1234_5678);
    chk("flush lo", 64'(lo), 64'd14);

    start = 1'b1; md_op = OP_MTLO; a = 32'hDEAD_BEEF; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_idle lo", 64'(lo), 64'd14);
    chk("flush_idle busy", 64'(busy), 64'd0);

    run_op("multu_after_flush", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0);

    // reset in cycle 20 of a DIV discards everything
    issue(OP_DIV, 32'd100, 32'd7);
    for (int i = 0; i < 19; i++) tick();
    chk("pre_rst busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst lo", 64'(lo), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
